// File: rtl/att_access_ctrl.sv
// att_access_ctrl
// Access controller for the address translation table (ATT) RAM pair:
// CT address RAM plus mask RAM sharing one address and one write enable.
// Config writes and CT-lookup reads share the single port. Ties between them
// are resolved round-robin. The controller steps through the 1-cycle
// synchronous read latency and holds each lookup result until the consumer
// takes it.
//
// Build option: define ATT_INIT_CLEAR_EN to zero-fill the whole table after
// every reset. During that sweep busy is high and no grants are issued.
module att_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CT_W   = 11,
  parameter int MASK_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  // lookup requester
  input  logic              lk_req,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_gnt,
  // lookup response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CT_W-1:0]   rsp_ct_addr,
  output logic [MASK_W-1:0] rsp_mask,
  // config write requester
  input  logic              cfg_req,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CT_W-1:0]   cfg_ct_addr,
  input  logic [MASK_W-1:0] cfg_mask,
  output logic              cfg_gnt,
  // RAM pair port
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [CT_W-1:0]   mem_data_ct,
  output logic [MASK_W-1:0] mem_data_mask,
  input  logic [CT_W-1:0]   mem_q_ct,
  input  logic [MASK_W-1:0] mem_q_mask,
  output logic              busy
);

  // S_IDLE : arbitrate and grant
  // S_RD   : RAM output is valid for the address granted last cycle
  // S_RSP  : result is presented until the consumer accepts it
  typedef enum logic [1:0] {
`ifdef ATT_INIT_CLEAR_EN
    S_INIT = 2'd0,
`endif
    S_IDLE = 2'd1,
    S_RD   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

`ifdef ATT_INIT_CLEAR_EN
  localparam state_t RST_STATE = S_INIT;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t              state_r;
  state_t              state_nxt_s;

  // 1: the most recent grant went to config, 0: it went to lookup.
  // The requester that was not served last wins a tie.
  logic                last_cfg_r;

  logic                rsp_valid_r;
  logic [CT_W-1:0]     rsp_ct_r;
  logic [MASK_W-1:0]   rsp_mask_r;

  logic                lk_gnt_s;
  logic                cfg_gnt_s;
  logic                mem_wren_s;
  logic [ADDR_W-1:0]   mem_address_s;
  logic [CT_W-1:0]     mem_ct_s;
  logic [MASK_W-1:0]   mem_mask_s;

`ifdef ATT_INIT_CLEAR_EN
  logic [ADDR_W-1:0]   init_cnt_r;
`endif

  // Next-state, grant and RAM-port decode. The port is idle (address and
  // data forced to zero) whenever nothing is granted. Grants and writes are
  // also blocked while reset is asserted.
  always_comb begin
    state_nxt_s   = state_r;
    lk_gnt_s      = 1'b0;
    cfg_gnt_s     = 1'b0;
    mem_wren_s    = 1'b0;
    mem_address_s = {ADDR_W{1'b0}};
    mem_ct_s      = {CT_W{1'b0}};
    mem_mask_s    = {MASK_W{1'b0}};
    case (state_r)
`ifdef ATT_INIT_CLEAR_EN
      S_INIT: begin
        if (rst) begin
          mem_wren_s    = 1'b1;
          mem_address_s = init_cnt_r;
        end else begin
          mem_wren_s    = 1'b0;
        end
        if (init_cnt_r == LAST_IDX) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_INIT;
        end
      end
`endif
      S_IDLE: begin
        if (rst && cfg_req && (!lk_req || !last_cfg_r)) begin
          cfg_gnt_s     = 1'b1;
          mem_wren_s    = 1'b1;
          mem_address_s = cfg_addr;
          mem_ct_s      = cfg_ct_addr;
          mem_mask_s    = cfg_mask;
          state_nxt_s   = S_IDLE;
        end else if (rst && lk_req) begin
          lk_gnt_s      = 1'b1;
          mem_address_s = lk_addr;
          state_nxt_s   = S_RD;
        end else begin
          state_nxt_s   = S_IDLE;
        end
      end
      S_RD: begin
        state_nxt_s = S_RSP;
      end
      S_RSP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RSP;
        end
      end
      default: begin
        state_nxt_s = RST_STATE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RST_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin history: remember which requester was granted last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_cfg_r <= 1'b0;
    end else if (cfg_gnt_s) begin
      last_cfg_r <= 1'b1;
    end else if (lk_gnt_s) begin
      last_cfg_r <= 1'b0;
    end
  end

  // Response holding registers: capture RAM q in S_RD, drop valid on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_r <= 1'b0;
      rsp_ct_r    <= {CT_W{1'b0}};
      rsp_mask_r  <= {MASK_W{1'b0}};
    end else if (state_r == S_RD) begin
      rsp_valid_r <= 1'b1;
      rsp_ct_r    <= mem_q_ct;
      rsp_mask_r  <= mem_q_mask;
    end else if ((state_r == S_RSP) && rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

`ifdef ATT_INIT_CLEAR_EN
  // Sweep index for the zero-fill. It restarts at 0 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt_r <= {ADDR_W{1'b0}};
    end else if (state_r == S_INIT) begin
      init_cnt_r <= init_cnt_r + IDX_ONE;
    end
  end

  assign busy = (state_r == S_INIT);
`else
  assign busy = 1'b0;
`endif

  assign lk_gnt        = lk_gnt_s;
  assign cfg_gnt       = cfg_gnt_s;
  assign mem_wren      = mem_wren_s;
  assign mem_address   = mem_address_s;
  assign mem_data_ct   = mem_ct_s;
  assign mem_data_mask = mem_mask_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_ct_addr   = rsp_ct_r;
  assign rsp_mask      = rsp_mask_r;

endmodule

// File: tb/tb_att_access_ctrl.sv
// tb_att_access_ctrl
// Self-checking bench for att_access_ctrl. A behavioural RAM pair is
// attached to the mem_* port. A transaction-level reference model predicts
// grants, port activity and responses every cycle. It keeps the expected
// table contents, who was served last, and the age of the outstanding lookup.
// The bench follows ATT_INIT_CLEAR_EN when that macro is defined.
module tb_att_access_ctrl;

  localparam int ADDR_W = 12;
  localparam int CT_W   = 11;
  localparam int MASK_W = 20;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lk_req = 1'b0;
  logic [ADDR_W-1:0] lk_addr = '0;
  logic              lk_gnt;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [CT_W-1:0]   rsp_ct_addr;
  logic [MASK_W-1:0] rsp_mask;
  logic              cfg_req = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [CT_W-1:0]   cfg_ct_addr = '0;
  logic [MASK_W-1:0] cfg_mask = '0;
  logic              cfg_gnt;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wren;
  logic [CT_W-1:0]   mem_data_ct;
  logic [MASK_W-1:0] mem_data_mask;
  logic [CT_W-1:0]   mem_q_ct;
  logic [MASK_W-1:0] mem_q_mask;
  logic              busy;

  always #5 clk = ~clk;

  att_access_ctrl #(.ADDR_W(ADDR_W), .CT_W(CT_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_gnt(lk_gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ct_addr(rsp_ct_addr), .rsp_mask(rsp_mask),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_ct_addr(cfg_ct_addr),
    .cfg_mask(cfg_mask), .cfg_gnt(cfg_gnt),
    .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_data_ct(mem_data_ct), .mem_data_mask(mem_data_mask),
    .mem_q_ct(mem_q_ct), .mem_q_mask(mem_q_mask), .busy(busy)
  );

  // Synchronous-read RAM pair (q valid the cycle after the address is sampled).
  logic [CT_W-1:0]   ram_ct   [DEPTH];
  logic [MASK_W-1:0] ram_mask [DEPTH];
  always @(posedge clk) begin
    if (mem_wren) begin
      ram_ct[mem_address]   <= mem_data_ct;
      ram_mask[mem_address] <= mem_data_mask;
    end
    mem_q_ct   <= ram_ct[mem_address];
    mem_q_mask <= ram_mask[mem_address];
  end

  // Reference model state
  logic [CT_W-1:0]   m_ct    [DEPTH];
  logic [MASK_W-1:0] m_mask  [DEPTH];
  bit                m_known [DEPTH];
  bit                m_last_cfg;
  bit                m_lk_busy;
  int                m_age;
  logic [CT_W-1:0]   m_rsp_ct;
  logic [MASK_W-1:0] m_rsp_mask;
  bit                m_rsp_known;
  int                m_sweep_left;
  bit                g_lk;
  bit                g_cfg;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_cfg  = 1'b0;
    m_lk_busy   = 1'b0;
    m_age       = 0;
    m_rsp_ct    = '0;
    m_rsp_mask  = '0;
    m_rsp_known = 1'b1;
    g_lk        = 1'b0;
    g_cfg       = 1'b0;
`ifdef ATT_INIT_CLEAR_EN
    m_sweep_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_ct[i]    = '0;
      m_mask[i]  = '0;
      m_known[i] = 1'b1;
    end
`else
    m_sweep_left = 0;
`endif
  endtask

  // One clock cycle. Inputs are applied by the caller at a negedge. This
  // task predicts and checks outputs, advances the model, and returns at
  // the next negedge.
  task automatic do_cycle();
    bit                e_lk, e_cfg, e_v, e_wren;
    logic [ADDR_W-1:0] e_addr;
    logic [CT_W-1:0]   e_dct;
    logic [MASK_W-1:0] e_dm;
    #1;
    e_v = m_lk_busy && (m_age >= 2);
    e_lk = 1'b0; e_cfg = 1'b0; e_wren = 1'b0;
    e_addr = '0; e_dct = '0; e_dm = '0;
    if (m_sweep_left > 0) begin
      e_wren = 1'b1;
      e_addr = ADDR_W'(DEPTH - m_sweep_left);
    end else if (!m_lk_busy) begin
      e_cfg = cfg_req && (!lk_req || !m_last_cfg);
      e_lk  = lk_req && !e_cfg;
    end
    if (e_cfg) begin
      e_wren = 1'b1; e_addr = cfg_addr; e_dct = cfg_ct_addr; e_dm = cfg_mask;
    end else if (e_lk) begin
      e_addr = lk_addr;
    end
    check_eq("lk_gnt",    32'(lk_gnt),        32'(e_lk));
    check_eq("cfg_gnt",   32'(cfg_gnt),       32'(e_cfg));
    check_eq("busy",      32'(busy),          32'(m_sweep_left > 0));
    check_eq("rsp_valid", 32'(rsp_valid),     32'(e_v));
    check_eq("mem_wren",  32'(mem_wren),      32'(e_wren));
    check_eq("mem_addr",  32'(mem_address),   32'(e_addr));
    check_eq("mem_dct",   32'(mem_data_ct),   32'(e_dct));
    check_eq("mem_dmask", 32'(mem_data_mask), 32'(e_dm));
    if (e_v && m_rsp_known) begin
      check_eq("rsp_ct",   32'(rsp_ct_addr), 32'(m_rsp_ct));
      check_eq("rsp_mask", 32'(rsp_mask),    32'(m_rsp_mask));
    end
    // advance the model to the state after this cycle's edge
    if (m_sweep_left > 0) m_sweep_left--;
    if (m_lk_busy) begin
      if (e_v && rsp_ready) m_lk_busy = 1'b0;
      else m_age++;
    end
    if (e_cfg) begin
      m_ct[cfg_addr]    = cfg_ct_addr;
      m_mask[cfg_addr]  = cfg_mask;
      m_known[cfg_addr] = 1'b1;
      m_last_cfg        = 1'b1;
    end
    if (e_lk) begin
      m_lk_busy   = 1'b1;
      m_age       = 1;
      m_rsp_ct    = m_ct[lk_addr];
      m_rsp_mask  = m_mask[lk_addr];
      m_rsp_known = m_known[lk_addr];
      m_last_cfg  = 1'b0;
    end
    g_lk  = e_lk;
    g_cfg = e_cfg;
    @(negedge clk);
  endtask

  // Assert reset part-way through a cycle, check the immediate effect, release at a negedge.
  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(rsp_valid),   32'd0);
    check_eq("rst_ct",    32'(rsp_ct_addr), 32'd0);
    check_eq("rst_mask",  32'(rsp_mask),    32'd0);
    check_eq("rst_lkgnt", 32'(lk_gnt),      32'd0);
    check_eq("rst_cfgnt", 32'(cfg_gnt),     32'd0);
    check_eq("rst_wren",  32'(mem_wren),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    while (m_sweep_left > 0) do_cycle();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [CT_W-1:0] c,
                          input logic [MASK_W-1:0] m);
    bit got;
    got = 1'b0;
    cfg_req = 1'b1; cfg_addr = a; cfg_ct_addr = c; cfg_mask = m;
    for (int k = 0; k < 40 && !got; k++) begin
      do_cycle();
      got = g_cfg;
    end
    cfg_req = 1'b0;
    if (!got) begin
      n_cmp++; n_mis++;
      $display("FAIL wr_timeout: no cfg_gnt within 40 cycles, expected a grant");
    end
  endtask

  task automatic do_lookup(input logic [ADDR_W-1:0] a, input logic [CT_W-1:0] c,
                           input logic [MASK_W-1:0] m);
    bit got;
    got = 1'b0;
    lk_req = 1'b1; lk_addr = a; rsp_ready = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      do_cycle();
      got = g_lk;
    end
    lk_req = 1'b0;
    if (!got) begin
      n_cmp++; n_mis++;
      $display("FAIL lk_timeout: no lk_gnt within 40 cycles, expected a grant");
    end else begin
      do_cycle();
      check_eq("lk_valid_n2", 32'(rsp_valid),   32'd1);
      check_eq("lk_ct_n2",    32'(rsp_ct_addr), 32'(c));
      check_eq("lk_mask_n2",  32'(rsp_mask),    32'(m));
      do_cycle();
    end
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 12'h000;
      1:       return 12'hFFF;
      2:       return 12'h005;
      3:       return 12'h7FF;
      4:       return ADDR_W'($urandom_range(0, 7));
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  initial begin
    @(negedge clk);
    // requests held during reset must not be granted
    lk_req = 1'b1; cfg_req = 1'b1;
    apply_reset();
    lk_req = 1'b0; cfg_req = 1'b0;

`ifdef ATT_INIT_CLEAR_EN
    // cleared table reads back as zero
    do_lookup(12'h7FF, 11'h000, 20'h00000);
`endif

    // 1: write then look up the same index
    do_write(12'h005, 11'h123, 20'hABCDE);
    do_lookup(12'h005, 11'h123, 20'hABCDE);

    // 2: both requesting from reset idle -> cfg first, then alternate
    apply_reset();
    lk_req = 1'b1; lk_addr = 12'h005; rsp_ready = 1'b1;
    cfg_req = 1'b1; cfg_addr = 12'h00A; cfg_ct_addr = 11'h055; cfg_mask = 20'h0F0F0;
    repeat (14) do_cycle();
    lk_req = 1'b0; cfg_req = 1'b0;
    repeat (4) do_cycle();

    // 3: consumer stalls 5 cycles while a second lookup waits
    lk_req = 1'b1; lk_addr = 12'h005; rsp_ready = 1'b0;
    do_cycle();
    lk_addr = 12'h00A;
    repeat (6) do_cycle();
    check_eq("t3_hold_ct",   32'(rsp_ct_addr), 32'h123);
    check_eq("t3_hold_mask", 32'(rsp_mask),    32'hABCDE);
    rsp_ready = 1'b1;
    do_cycle();
    do_cycle();
    lk_req = 1'b0;
    repeat (4) do_cycle();

    // 4: back-to-back writes at both ends of the index range
    do_write(12'hFFF, 11'h7FF, 20'hFFFFF);
    do_write(12'h000, 11'h001, 20'h00001);
    do_lookup(12'hFFF, 11'h7FF, 20'hFFFFF);
    do_lookup(12'h000, 11'h001, 20'h00001);

    // 5: reset while a response is held
    lk_req = 1'b1; lk_addr = 12'h005; rsp_ready = 1'b0;
    do_cycle();
    lk_req = 1'b0;
    do_cycle();
    check_eq("t5_pre_valid", 32'(rsp_valid), 32'd1);
    apply_reset();
    do_write(12'h005, 11'h456, 20'h12345);
    do_lookup(12'h005, 11'h456, 20'h12345);

    // randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 2500; c++) begin
      if (!lk_req || g_lk) begin
        lk_req  = ($urandom_range(0, 1) == 1);
        lk_addr = pick_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        lk_req = 1'b0;
      end
      if (!cfg_req || g_cfg) begin
        cfg_req     = ($urandom_range(0, 2) == 0);
        cfg_addr    = pick_addr();
        cfg_ct_addr = CT_W'($urandom);
        cfg_mask    = MASK_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        cfg_req = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (c == 1200) apply_reset();
      else do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
